// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: FSM state enum, RV32I funct3 size codes, memory size code,
//           and the request legality/alignment helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_ADDR = 3'd1,
    LD_DATA = 3'd2,
    ST_WR   = 3'd3,
    RMW_RD  = 3'd4,
    RMW_WR  = 3'd5,
    RESP    = 3'd6
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size code driven on mem_wr_strb: the memory always sees full-word writes.
  localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

  // True when the size code is legal for the direction and the address is
  // naturally aligned for that size.
  function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    // LH and LHU/SH all share low bits 01.
    if ((f3[1:0] == 2'b01) && addr_lo[0]) ok = 1'b0;
    if ((f3 == F3_W) && (addr_lo != 2'b00)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store lane merge.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: funct3/byte_off select size and lane; rdata is the memory word;
//        wdata is right-aligned store data; load_data and merged are results.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (byte_off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Sub-word stores keep the untouched lanes of the word read back first.
  always_comb begin
    merged = wdata;
    case (funct3)
      F3_B: begin
        merged = rdata;
        case (byte_off)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = rdata;
        endcase
      end
      F3_H: begin
        merged = rdata;
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port word memory with registered read.
// Latency: load 3 cycles, word store 2, sub-word store 3 (read-modify-write),
//          error 1. Backpressure: req_ready only in IDLE; responses never stall.
// Ports: req_* request handshake, rsp_* one-cycle completion, mem_* memory side.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 4,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic [AW-1:0] mem_rd_addr0,
  output logic [AW-1:0] mem_wr_addr0,
  output logic [31:0]   mem_wr_din0,
  output logic          mem_we0,
  output logic [2:0]    mem_wr_strb,
  input  logic [31:0]   mem_rd_dout0
);

  lsu_state_t  state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Address bits above the word index wrap away.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{r_addr[31:AW+2], r_we};

  lsu_align u_align (
    .funct3    (r_funct3),
    .byte_off  (r_addr[1:0]),
    .rdata     (mem_rd_dout0),
    .wdata     (r_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  assign req_ready    = (state == IDLE);
  assign mem_rd_addr0 = r_addr[AW+1:2];
  assign mem_wr_addr0 = r_addr[AW+1:2];
  // Word stores pass straight through the merge; sub-word stores merge
  // against the word read during RMW_RD.
  assign mem_wr_din0  = merged;
  // Gated by rst so a reset landing on RMW_WR never corrupts memory.
  assign mem_we0      = ((state == ST_WR) || (state == RMW_WR)) && !rst;
  assign mem_wr_strb  = mem_we0 ? MEM_SIZE_WORD : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (!req_legal(req_we, req_funct3, req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (!req_we) begin
              state <= LD_ADDR;
            end else if (req_funct3 == F3_W) begin
              state <= ST_WR;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LD_ADDR: state <= LD_DATA;
        LD_DATA: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
          rsp_error <= 1'b0;
        end
        RMW_RD: state <= RMW_WR;
        ST_WR, RMW_WR: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'h0;
          rsp_error <= 1'b0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a registered-read word memory.
module tb_load_store_unit;

  localparam int MEM_DEPTH = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] mem_rd_addr0;
  logic [AW-1:0] mem_wr_addr0;
  logic [31:0]   mem_wr_din0;
  logic          mem_we0;
  logic [2:0]    mem_wr_strb;
  logic [31:0]   mem_rd_dout0;

  logic [31:0] mem [MEM_DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_rd_addr0 (mem_rd_addr0),
    .mem_wr_addr0 (mem_wr_addr0),
    .mem_wr_din0  (mem_wr_din0),
    .mem_we0      (mem_we0),
    .mem_wr_strb  (mem_wr_strb),
    .mem_rd_dout0 (mem_rd_dout0)
  );

  // Memory model: one-cycle registered read, synchronous write.
  always @(posedge clk) begin
    mem_rd_dout0 <= mem[mem_rd_addr0];
    if (mem_we0) mem[mem_wr_addr0] <= mem_wr_din0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (T); returns 1 time unit into T+1.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    check("ready_at_T", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] idx;
    idx = {30'h0, addr[3:2]};
    issue(1'b0, f3, addr, 32'h0);
    check({tag, "_busy_T1"}, {31'h0, req_ready}, 32'h0);
    check({tag, "_rdaddr"}, {30'h0, mem_rd_addr0}, idx);
    check({tag, "_novld_T1"}, {31'h0, rsp_valid}, 32'h0);
    step();
    check({tag, "_novld_T2"}, {31'h0, rsp_valid}, 32'h0);
    step();
    check({tag, "_vld_T3"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_rdata"}, rsp_rdata, exp);
    check({tag, "_err"}, {31'h0, rsp_error}, 32'h0);
    step();
    check({tag, "_vld_drop"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_rdata_hold"}, rsp_rdata, exp);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_idx, input logic [31:0] exp_din);
    issue(1'b1, f3, addr, wdata);
    if (f3 != 3'b010) begin
      check({tag, "_no_we_rmw_rd"}, {31'h0, mem_we0}, 32'h0);
      step();
    end
    check({tag, "_we"}, {31'h0, mem_we0}, 32'h1);
    check({tag, "_wraddr"}, {30'h0, mem_wr_addr0}, exp_idx);
    check({tag, "_din"}, mem_wr_din0, exp_din);
    check({tag, "_strb"}, {29'h0, mem_wr_strb}, 32'h2);
    check({tag, "_novld"}, {31'h0, rsp_valid}, 32'h0);
    step();
    check({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_rdata0"}, rsp_rdata, 32'h0);
    check({tag, "_err0"}, {31'h0, rsp_error}, 32'h0);
    check({tag, "_we_off"}, {31'h0, mem_we0}, 32'h0);
    step();
  endtask

  task automatic do_error(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    check({tag, "_no_we_T"}, {31'h0, mem_we0}, 32'h0);
    issue(we, f3, addr, 32'h5555_5555);
    check({tag, "_vld_T1"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_err"}, {31'h0, rsp_error}, 32'h1);
    check({tag, "_rdata0"}, rsp_rdata, 32'h0);
    check({tag, "_no_we_T1"}, {31'h0, mem_we0}, 32'h0);
    step();
    check({tag, "_vld_drop"}, {31'h0, rsp_valid}, 32'h0);
    check({tag, "_err_hold"}, {31'h0, rsp_error}, 32'h1);
  endtask

  initial begin
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h8899_AABB;
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h0000_0000;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    step();
    step();
    rst = 1'b0;
    #1;

    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
    check("reset_we0", {31'h0, mem_we0}, 32'h0);
    check("reset_strb", {29'h0, mem_wr_strb}, 32'h0);
    step();

    do_load("lb_7",  3'b000, 32'h7, 32'hFFFF_FF88);
    do_load("lhu_6", 3'b101, 32'h6, 32'h0000_8899);
    do_load("lh_4",  3'b001, 32'h4, 32'hFFFF_AABB);
    do_load("lbu_5", 3'b100, 32'h5, 32'h0000_00AA);

    do_store("sb_5", 3'b000, 32'h5, 32'h0000_00CC, 32'h1, 32'h8899_CCBB);
    do_load("lw_4_after_sb", 3'b010, 32'h4, 32'h8899_CCBB);

    do_store("sw_8", 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h2, 32'hDEAD_BEEF);
    do_load("lw_18_wrap", 3'b010, 32'h18, 32'hDEAD_BEEF);
    do_store("sh_a", 3'b001, 32'hA, 32'h0000_1234, 32'h2, 32'h1234_BEEF);
    do_load("lb_b", 3'b000, 32'hB, 32'h0000_0012);

    do_error("lw_mis_6", 1'b0, 3'b010, 32'h6);
    do_error("ld_f3_011", 1'b0, 3'b011, 32'h0);
    do_error("sh_mis_5", 1'b1, 3'b001, 32'h5);
    do_error("st_f3_100", 1'b1, 3'b100, 32'h4);
    do_load("lw_4_after_err", 3'b010, 32'h4, 32'h8899_CCBB);

    // Reset landing on the RMW write cycle must suppress the write and response.
    issue(1'b1, 3'b000, 32'h4, 32'h0000_0011);
    step();
    check("rmw_abort_we_before_rst", {31'h0, mem_we0}, 32'h1);
    rst = 1'b1;
    #1;
    check("rmw_abort_we_gated", {31'h0, mem_we0}, 32'h0);
    check("rmw_abort_strb_gated", {29'h0, mem_wr_strb}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("rmw_abort_idle", {31'h0, req_ready}, 32'h1);
    check("rmw_abort_no_vld", {31'h0, rsp_valid}, 32'h0);
    check("rmw_abort_rdata_clr", rsp_rdata, 32'h0);
    step();
    check("rmw_abort_no_vld_late", {31'h0, rsp_valid}, 32'h0);
    do_load("lw_4_after_abort", 3'b010, 32'h4, 32'h8899_CCBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_DEPTH, default 4, data-memory depth in 32-bit words; AW = $clog2(MEM_DEPTH), MEM_DEPTH >= 2.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port clk, in, 1: sole clock, rising edge.
REQ-004 Port rst, in, 1: synchronous active-high reset.
REQ-005 Port req_valid, in, 1: pipeline presents a request.
REQ-006 Port req_ready, out, 1: unit can accept a request.
REQ-007 Port req_we, in, 1: 1 = store, 0 = load.
REQ-008 Port req_funct3, in, 3: RV32I size/sign code.
REQ-009 Port req_addr, in, 32: byte address.
REQ-010 Port req_wdata, in, 32: store data, right-aligned.
REQ-011 Port rsp_valid, out, 1: one-cycle completion pulse.
REQ-012 Port rsp_rdata, out, 32: extended load data; 0 for stores and errors.
REQ-013 Port rsp_error, out, 1: misaligned or illegal request.
REQ-014 Ports mem_rd_addr0 and mem_wr_addr0, out, AW each: word index into memory.
REQ-015 Port mem_wr_din0, out, 32: full-word write data.
REQ-016 Port mem_we0, out, 1: memory write enable.
REQ-017 Port mem_wr_strb, out, 3: write size code.
REQ-018 Port mem_rd_dout0, in, 32: registered memory read data, valid the cycle after the address.

Function
REQ-019 The FSM SHALL have states IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_WR and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready; the accept cycle is T.
REQ-021 On accept, req_we, req_funct3, req_addr and req_wdata SHALL be registered; inputs are ignored outside IDLE.
REQ-022 Legal loads SHALL be LB 000, LH 001, LW 010, LBU 100 and LHU 101; legal stores SHALL be SB 000, SH 001 and SW 010; every other code is illegal.
REQ-023 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; illegal or misaligned SHALL go IDLE->RESP with rsp_error=1, rsp_valid at T+1, no memory write.
REQ-024 Load: IDLE->LD_ADDR (T+1)->LD_DATA (T+2, capture extracted and extended data)->RESP (T+3).
REQ-025 Word store: IDLE->ST_WR (T+1, mem_we0=1)->RESP (T+2).
REQ-026 Byte/half store: IDLE->RMW_RD (T+1)->RMW_WR (T+2, mem_we0=1, din = mem_rd_dout0 with addressed lanes replaced)->RESP (T+3).
REQ-027 RESP SHALL assert rsp_valid for exactly one cycle, then go to IDLE; no response backpressure.
REQ-028 Both memory addresses SHALL always equal registered addr[AW+1:2]; upper bits are ignored (address wraps modulo MEM_DEPTH words).
REQ-029 mem_wr_strb SHALL be 3'b010 whenever mem_we0=1, else 3'b000; mem_we0 is 1 only in ST_WR and RMW_WR.
REQ-030 Byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-031 rsp_rdata and rsp_error SHALL hold their last values between responses.

Reset
REQ-032 rst SHALL force IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0 and all request registers to 0 at the next edge.
REQ-033 mem_we0 SHALL be gated by !rst, so there is no write in a cycle where rst=1, including mid-RMW; the aborted request gets no response.

Structure
REQ-034 Package lsu_pkg SHALL hold the state enum, funct3 constants and MEM_SIZE_WORD=3'b010.
REQ-035 A combinational sub-module lsu_align SHALL perform load extract/extend and store lane merge.

Verification (word1 preloaded 0x8899AABB)
REQ-036 LB addr 0x7 -> rsp_valid at T+3, rdata 0xFFFFFF88, error 0.
REQ-037 LHU addr 0x6 -> rdata 0x00008899 at T+3.
REQ-038 SB addr 0x5 wdata 0xCC -> at T+2 we0=1, wr_addr0=1, din 0x8899CCBB, strb 010; rsp at T+3.
REQ-039 SW addr 0x8 wdata 0xDEADBEEF -> we0 at T+1, wr_addr0=2; rsp at T+2, rdata 0.
REQ-040 LW addr 0x6, and separately funct3 011 -> rsp at T+1, error=1, no we0.
REQ-041 rst=1 in the RMW_WR cycle -> we0=0, IDLE next cycle, no rsp, memory unchanged.
